// File: rtl/bf16_result_buffer.sv
// Result buffer behind bf16_accelerator_top: captures every flagged result
// with its fpcsr and op code, presents them in order on a valid/ready port,
// and keeps sticky exception and overflow indicators for software.
module bf16_result_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_result,
  input  logic [3:0]                 in_fpcsr,
  input  logic [3:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [3:0]                 out_fpcsr,
  output logic [3:0]                 out_op,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic [3:0]                 sticky_fpcsr,
  output logic                       overflow,
  input  logic                       clear_sticky
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);

  logic [31:0]   result_mem [DEPTH];
  logic [3:0]    fpcsr_mem  [DEPTH];
  logic [3:0]    op_mem     [DEPTH];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          full;
  logic          pop;
  logic          accept;
  logic          drop;

  // Handshake decode; a push at full is only taken when the head leaves too.
  always_comb begin
    full   = (count == FULL_COUNT);
    pop    = out_valid & out_ready;
    accept = in_valid & (~full | pop);
    drop   = in_valid & full & ~pop;
  end

  // Head presentation, masked to zero while the buffer is empty.
  always_comb begin
    out_valid   = (count != '0);
    almost_full = (count >= AF_COUNT);
    out_result  = '0;
    out_fpcsr   = '0;
    out_op      = '0;
    if (out_valid) begin
      out_result = result_mem[rp];
      out_fpcsr  = fpcsr_mem[rp];
      out_op     = op_mem[rp];
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      result_mem[wp] <= in_result;
      fpcsr_mem[wp]  <= in_fpcsr;
      op_mem[wp]     <= in_op;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (accept) wp <= wp + 1'b1;
      if (pop)    rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
    end
  end

  // Sticky flags: a same-cycle event always wins over clear_sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_fpcsr <= '0;
      overflow     <= 1'b0;
    end else begin
      if (in_valid)
        sticky_fpcsr <= (clear_sticky ? 4'b0000 : sticky_fpcsr) | in_fpcsr;
      else if (clear_sticky)
        sticky_fpcsr <= '0;
      if (drop)
        overflow <= 1'b1;
      else if (clear_sticky)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bf16_result_buffer.sv
// Directed bench for bf16_result_buffer with hand-computed expectations.
module tb_bf16_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_result;
  logic [3:0]  in_fpcsr;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_fpcsr;
  logic [3:0]  out_op;
  logic [2:0]  count;
  logic        almost_full;
  logic [3:0]  sticky_fpcsr;
  logic        overflow;
  logic        clear_sticky;

  int checks = 0;
  int errors = 0;

  bf16_result_buffer #(.DEPTH(4), .AF_LEVEL(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_result(in_result), .in_fpcsr(in_fpcsr), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_fpcsr(out_fpcsr), .out_op(out_op), .count(count),
    .almost_full(almost_full), .sticky_fpcsr(sticky_fpcsr),
    .overflow(overflow), .clear_sticky(clear_sticky)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] r, input logic [3:0] f, input logic [3:0] o);
    in_valid  = 1'b1;
    in_result = r;
    in_fpcsr  = f;
    in_op     = o;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_fpcsr = '0; in_op = '0;
    out_ready = 1'b0; clear_sticky = 1'b0;
    step(); step();
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_out_result", out_result, 0);
    rst = 1'b0;
    step();
    check_eq("rst_sticky", 32'(sticky_fpcsr), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_almost_full", 32'(almost_full), 0);

    // 1: single pass-through
    out_ready = 1'b1;
    push(32'h00004049, 4'b0000, 4'b0001);
    check_eq("t1_out_valid", 32'(out_valid), 1);
    check_eq("t1_out_result", out_result, 32'h00004049);
    check_eq("t1_out_op", 32'(out_op), 1);
    check_eq("t1_count1", 32'(count), 1);
    step();
    check_eq("t1_count0", 32'(count), 0);
    check_eq("t1_valid0", 32'(out_valid), 0);
    check_eq("t1_sticky", 32'(sticky_fpcsr), 0);

    // 2: fill and order
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push(32'(i), 4'b0000, 4'(i));
      check_eq("t2_count", 32'(count), 32'(i));
      check_eq("t2_almost_full", 32'(almost_full), (i >= 3) ? 1 : 0);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("t2_order", out_result, 32'(i));
      check_eq("t2_op", 32'(out_op), 32'(i));
      step();
    end
    check_eq("t2_empty", 32'(out_valid), 0);

    // 3: overflow drop at full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(10 + i), 4'b0000, 4'b0010);
    push(32'h7FC00000, 4'b0001, 4'b0011);
    check_eq("t3_count", 32'(count), 4);
    check_eq("t3_overflow", 32'(overflow), 1);
    check_eq("t3_sticky", 32'(sticky_fpcsr), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_drain", out_result, 32'(10 + i));
      step();
    end
    check_eq("t3_empty", 32'(out_valid), 0);
    check_eq("t3_overflow_held", 32'(overflow), 1);

    // clear before the next case
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    check_eq("clr_overflow", 32'(overflow), 0);
    check_eq("clr_sticky", 32'(sticky_fpcsr), 0);

    // 4: push and pop together at full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(20 + i), 4'b0000, 4'b0100);
    check_eq("t4_full", 32'(count), 4);
    out_ready = 1'b1;
    push(32'h7F800000, 4'b0000, 4'b0101);
    check_eq("t4_count", 32'(count), 4);
    check_eq("t4_overflow", 32'(overflow), 0);
    for (int i = 1; i < 4; i++) begin
      check_eq("t4_drain", out_result, 32'(20 + i));
      step();
    end
    check_eq("t4_fifth", out_result, 32'h7F800000);
    check_eq("t4_fifth_op", 32'(out_op), 5);
    step();
    check_eq("t4_empty", 32'(out_valid), 0);

    // 5: sticky clear collisions
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'(30 + i), 4'b0000, 4'b0110);
    push(32'h00000099, 4'b0011, 4'b0111);
    check_eq("t5_sticky3", 32'(sticky_fpcsr), 3);
    check_eq("t5_overflow", 32'(overflow), 1);
    clear_sticky = 1'b1;
    push(32'h00000098, 4'b0100, 4'b0111);
    check_eq("t5_sticky_new_wins", 32'(sticky_fpcsr), 4);
    check_eq("t5_overflow_drop_wins", 32'(overflow), 1);
    step();
    clear_sticky = 1'b0;
    check_eq("t5_sticky_cleared", 32'(sticky_fpcsr), 0);
    check_eq("t5_overflow_cleared", 32'(overflow), 0);
    check_eq("t5_contents_kept", 32'(count), 4);
    check_eq("t5_head", out_result, 30);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("t5_empty", 32'(count), 0);

    // 6: asynchronous reset mid-stream
    out_ready = 1'b0;
    push(32'd40, 4'b1000, 4'b0001);
    push(32'd41, 4'b0000, 4'b0001);
    check_eq("t6_count2", 32'(count), 2);
    check_eq("t6_sticky8", 32'(sticky_fpcsr), 8);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_async_valid", 32'(out_valid), 0);
    check_eq("t6_async_count", 32'(count), 0);
    check_eq("t6_async_sticky", 32'(sticky_fpcsr), 0);
    check_eq("t6_async_result", out_result, 0);
    check_eq("t6_async_overflow", 32'(overflow), 0);
    #1 rst = 1'b0;
    push(32'd50, 4'b0000, 4'b0010);
    check_eq("t6_after_valid", 32'(out_valid), 1);
    check_eq("t6_after_result", out_result, 50);
    check_eq("t6_after_count", 32'(count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf16_result_buffer.md
Name: bf16_result_buffer

Overview:
- Downstream stage of bf16_accelerator_top. Captures every result the accelerator flags with its one-cycle valid pulse, together with fpcsr and the operation code that produced it.
- The accelerator has no backpressure, so this block supplies the elastic storage between it and the consumer: register-file writeback or bus slave.
- Presents results in order on a valid/ready interface.
- Keeps sticky exception flags and a sticky overflow indicator for software.

Parameters:
DEPTH, 4, number of result entries; power of two, at least 2
AF_LEVEL, 3, count at or above which almost_full asserts; 1 to DEPTH

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  accelerator valid pulse; one entry per cycle high
in_result  input  32  accelerator result
in_fpcsr  input  4  accelerator fpcsr for this result
in_op  input  4  operation code issued for this result
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_result  output  32  head entry result
out_fpcsr  output  4  head entry fpcsr
out_op  output  4  head entry operation code
count  output  $clog2(DEPTH)+1  entries currently stored
almost_full  output  1  count >= AF_LEVEL; upstream issue logic stalls new operations on it
sticky_fpcsr  output  4  bitwise OR of fpcsr of all results received since the last clear
overflow  output  1  sticky; a result was dropped because the buffer was full
clear_sticky  input  1  clears sticky_fpcsr and overflow

Behaviour:
Reset:
- Asynchronous; takes effect immediately while reset is high.
- Pointers, count, sticky_fpcsr and overflow go to 0; out_valid is 0.
- out_result, out_fpcsr and out_op read 0.
- Storage contents need not be reset, but outputs are masked to 0 while empty.
- Reset mid-stream discards all entries without emitting them.

Push and pop rules:
- push = in_valid. pop = out_valid & out_ready.
- The buffer is a circular FIFO with write pointer wp and read pointer rp, each $clog2(DEPTH) bits. Both wrap naturally from DEPTH-1 to 0.
- Push accepted when count < DEPTH, or when count == DEPTH and pop is high in the same cycle. A simultaneous push and pop at full is legal and count stays at DEPTH.
- Push rejected when count == DEPTH and no pop: data is dropped, pointers and count are unchanged, and overflow sets to 1 on the next edge.
- Pop when empty cannot occur because out_valid is 0. out_ready while empty is ignored.
- count next = count + accepted_push - pop.

Latency and output timing:
- An entry pushed at edge N is visible on the out_* outputs with out_valid = 1 after edge N, when the buffer was empty. There is one cycle of latency and no combinational path from in_* to out_*.
- Outputs show storage[rp] combinationally from registered state.
- Head data stays stable while out_valid = 1 and out_ready = 0.
- Ordering is strict FIFO.

Sticky flags:
- On every in_valid, sticky_fpcsr |= in_fpcsr, whether or not the push is accepted.
- clear_sticky in the same cycle as in_valid: sticky_fpcsr = in_fpcsr. The new event wins over the clear.
- clear_sticky with an overflow drop in the same cycle: overflow = 1.
- clear_sticky alone zeroes both on the next edge.
- FIFO contents are unaffected by clear_sticky.

almost_full is combinational from the count register.

Test Plan:
1. Single pass-through: reset, then one in_valid with in_result=32'h00004049, in_fpcsr=4'b0000, in_op=4'b0001, out_ready=1 -> out_valid high one cycle after the push edge with out_result=32'h00004049 and out_op=4'b0001; count returns to 0; sticky_fpcsr=0.
2. Fill and order: out_ready=0, push results 1, 2, 3, 4 on consecutive cycles -> count=4 and almost_full=1 once count reaches 3; then out_ready=1 -> outputs 1, 2, 3, 4 in order on successive cycles, then out_valid=0.
3. Overflow: with the buffer full and out_ready=0, push 32'h7FC00000 with fpcsr=4'b0001 -> entry dropped, count stays 4, overflow=1, sticky_fpcsr bit0=1; draining returns only the original 4 entries.
4. Full with simultaneous push and pop: buffer full, out_ready=1 and in_valid=1 with 32'h7F800000 -> push accepted, count stays 4, no overflow; the new value emerges fifth, after pointer wrap.
5. Sticky clear collision: sticky_fpcsr=4'b0011, assert clear_sticky together with in_valid carrying fpcsr=4'b0100 -> sticky_fpcsr=4'b0100; next cycle clear_sticky alone -> 0, with overflow also 0 if it was set.
6. Async reset mid-stream: count=2, assert reset between clock edges -> out_valid, count, overflow and sticky_fpcsr drop to 0 immediately; after deassertion, a new push appears normally one cycle later.
